// File: rtl/tmr_pkg.sv
// Shared definitions for the multi-channel PWM timer: count-mode codes,
// counting direction and run-mode encodings.
package tmr_pkg;

    localparam logic [1:0] CM_UP     = 2'd0;
    localparam logic [1:0] CM_DOWN   = 2'd1;
    localparam logic [1:0] CM_CENTER = 2'd2;
    localparam logic [1:0] CM_UP_ALT = 2'd3;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    typedef enum logic {
        MODE_ONESHOT  = 1'b0,
        MODE_PERIODIC = 1'b1
    } mode_e;

endpackage

// File: rtl/tmr_cmp_ch.sv
// One compare/PWM channel: shadowed compare value, sticky match flag and
// registered PWM output derived from the shared counter.
module tmr_cmp_ch
    import tmr_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         tick,
    input  logic         bnd,
    input  logic [W-1:0] cnt,
    input  logic [W-1:0] cmp_pre,
    input  logic         pwm_en,
    input  logic         pol,
    input  logic         clr,
    output logic         cmpf,
    output logic         pwm
);

    logic [W-1:0] cmp_a;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmp_a <= '0;
            cmpf  <= 1'b0;
            pwm   <= 1'b0;
        end else if (!en) begin
            cmp_a <= cmp_pre;
            cmpf  <= 1'b0;
            pwm   <= 1'b0;
        end else begin
            pwm <= pwm_en & (pol ^ (cnt < cmp_a));
            // A clear in the same cycle as a match keeps the flag low.
            if (clr)
                cmpf <= 1'b0;
            else if (tick && (cnt == cmp_a))
                cmpf <= 1'b1;
            // Compare changes only land on a period boundary, so no runt pulses.
            if (bnd)
                cmp_a <= cmp_pre;
        end
    end

endmodule

// File: rtl/tmr_pwm_nch.sv
// W-bit timer with prescaler, up/down/center counting, double-buffered
// period and NCH compare/PWM channels sharing one interrupt line.
module tmr_pwm_nch
    import tmr_pkg::*;
#(
    parameter int W   = 32,
    parameter int PW  = 16,
    parameter int NCH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             EN,
    input  logic [PW-1:0]    PRE,
    input  logic [W-1:0]     PERIOD,
    input  logic [NCH*W-1:0] CMP,
    input  logic [1:0]       CM,
    input  logic             MODE,
    input  logic [NCH-1:0]   PWMEN,
    input  logic [NCH-1:0]   POL,
    input  logic [NCH:0]     IE,
    input  logic             OVF_CLR,
    input  logic [NCH-1:0]   CMPF_CLR,
    output logic [W-1:0]     TMR,
    output logic             OVF,
    output logic [NCH-1:0]   CMPF,
    output logic             DONE,
    output logic [NCH-1:0]   PWM,
    output logic             IRQ
);

    logic [PW-1:0] pre;
    logic [W-1:0]  cnt;
    logic [W-1:0]  cnt_nxt;
    logic [W-1:0]  per_a;
    logic [1:0]    cm_a;
    mode_e         mode_a;
    dir_e          dir;
    dir_e          dir_nxt;
    logic          tick;
    logic          bnd;

    assign tick = EN & (pre == PRE) & ~DONE;

    always_comb begin
        cnt_nxt = cnt;
        dir_nxt = dir;
        bnd     = 1'b0;
        if (tick) begin
            if (per_a == '0) begin
                cnt_nxt = '0;
                bnd     = 1'b1;
            end else begin
                case (cm_a)
                    CM_DOWN: begin
                        // Reload takes the new top value, which becomes per_a this same cycle.
                        if (cnt == '0) begin
                            cnt_nxt = PERIOD;
                            bnd     = 1'b1;
                        end else begin
                            cnt_nxt = cnt - 1'b1;
                        end
                    end
                    CM_CENTER: begin
                        if (dir == DIR_UP) begin
                            if (cnt == per_a) begin
                                dir_nxt = DIR_DOWN;
                                cnt_nxt = cnt - 1'b1;
                            end else begin
                                cnt_nxt = cnt + 1'b1;
                            end
                        end else begin
                            if (cnt == '0) begin
                                dir_nxt = DIR_UP;
                                cnt_nxt = cnt + 1'b1;
                                bnd     = 1'b1;
                            end else begin
                                cnt_nxt = cnt - 1'b1;
                            end
                        end
                    end
                    default: begin
                        if (cnt == per_a) begin
                            cnt_nxt = '0;
                            bnd     = 1'b1;
                        end else begin
                            cnt_nxt = cnt + 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre    <= '0;
            cnt    <= '0;
            per_a  <= '0;
            cm_a   <= CM_UP;
            mode_a <= MODE_ONESHOT;
            dir    <= DIR_UP;
            OVF    <= 1'b0;
            DONE   <= 1'b0;
        end else if (!EN) begin
            // Idle: keep the active copies tracking the preload so a start is clean.
            pre    <= '0;
            dir    <= DIR_UP;
            OVF    <= 1'b0;
            DONE   <= 1'b0;
            per_a  <= PERIOD;
            cm_a   <= CM;
            mode_a <= mode_e'(MODE);
            cnt    <= (CM == CM_DOWN) ? PERIOD : '0;
        end else begin
            pre <= (pre == PRE) ? '0 : pre + 1'b1;
            cnt <= cnt_nxt;
            dir <= dir_nxt;
            if (OVF_CLR)
                OVF <= 1'b0;
            else if (bnd)
                OVF <= 1'b1;
            if (bnd)
                per_a <= PERIOD;
            if (bnd && (mode_a == MODE_ONESHOT))
                DONE <= 1'b1;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        tmr_cmp_ch #(
            .W(W)
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (EN),
            .tick    (tick),
            .bnd     (bnd),
            .cnt     (cnt),
            .cmp_pre (CMP[i*W +: W]),
            .pwm_en  (PWMEN[i]),
            .pol     (POL[i]),
            .clr     (CMPF_CLR[i]),
            .cmpf    (CMPF[i]),
            .pwm     (PWM[i])
        );
    end

    assign TMR = cnt;
    assign IRQ = |({CMPF, OVF} & IE);

endmodule
